itype_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the I-type execute core (top).
//  - Generates the PC and issues in-order requests to instruction memory.
//  - Buffers returned words in a DEPTH-entry prefetch FIFO.
//  - Presents words to the execute stage over a valid/ready handshake.
//  - Supports flush/redirect with discard of in-flight responses.

---
 rtl/itype_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_itype_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/itype_fetch_unit.sv
// In-order instruction fetch with DEPTH-entry prefetch FIFO and flush/drain; ITYPE_ILLEGAL_FILTER_EN swaps non-OP-IMM words for NOP.
// Latency: request issued the cycle after reset; response word visible on instr_* one cycle after rsp_valid.
// Backpressure: requests are credit-limited (FIFO entries + outstanding < DEPTH), so responses are never stalled.
module itype_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              illegal_seen
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     outstanding, drop, drop_nxt, count;
    logic [CW:0]       credit_used;
    logic              req_fire, push, pop;
    logic [31:0]       push_data;

    logic [31:0]       dmem [DEPTH];
    logic [ADDR_W-1:0] pmem [DEPTH];
    logic [ADDR_W-1:0] pcq  [DEPTH];
    logic [PW-1:0]     d_wr, d_rd, q_wr, q_rd;
    logic [31:0]       hold_data;
    logic [ADDR_W-1:0] hold_pc;

    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = (state == FETCH) && !flush && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && (state == FETCH) && !flush;
    assign instr_valid    = (count != '0);
    assign pop            = instr_valid && instr_ready && !flush;
    assign instr_data     = instr_valid ? dmem[d_rd] : hold_data;
    assign instr_pc       = instr_valid ? pmem[d_rd] : hold_pc;

`ifdef ITYPE_ILLEGAL_FILTER_EN
    logic rsp_legal;
    assign rsp_legal = (imem_rsp_data[6:0] == 7'b0010011);
    assign push_data = rsp_legal ? imem_rsp_data : 32'h0000_0013;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else if (push && !rsp_legal) begin
            illegal_seen <= 1'b1;
        end
    end
`else
    assign push_data    = imem_rsp_data;
    assign illegal_seen = 1'b0;
`endif

    // Responses still owed to flushed requests are counted down in DRAIN.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        case (state)
            FETCH: begin
                if (flush) begin
                    drop_nxt = outstanding - CW'(imem_rsp_valid);
                    if (drop_nxt != '0) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    drop_nxt = drop - CW'(1);
                    if (drop_nxt == '0) state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            drop        <= '0;
            pc          <= RESET_PC;
            outstanding <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            d_wr        <= '0;
            d_rd        <= '0;
            count       <= '0;
            hold_data   <= '0;
            hold_pc     <= '0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            if (count != '0) begin
                hold_data <= dmem[d_rd];
                hold_pc   <= pmem[d_rd];
            end
            if (flush) begin
                pc          <= flush_pc;
                outstanding <= '0;
                q_wr        <= '0;
                q_rd        <= '0;
                d_wr        <= '0;
                d_rd        <= '0;
                count       <= '0;
            end else begin
                if (req_fire) begin
                    pc   <= pc + ADDR_W'(4);
                    q_wr <= q_wr + PW'(1);
                end
                if (state == FETCH) outstanding <= outstanding + CW'(req_fire) - CW'(push);
                if (push) begin
                    q_rd <= q_rd + PW'(1);
                    d_wr <= d_wr + PW'(1);
                end
                if (pop) d_rd <= d_rd + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (req_fire) pcq[q_wr] <= pc;
        if (push) begin
            dmem[d_wr] <= push_data;
            pmem[d_wr] <= pcq[q_rd];
        end
    end

endmodule

// File: tb/tb_itype_fetch_unit.sv
// Randomized bench for itype_fetch_unit: a memory model answers requests in order, a scoreboard
// queue holds the expected {pc, word} stream, and a negedge monitor compares the FIFO head.
module tb_itype_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk, rst;
    logic              imem_req_valid, imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              instr_valid, instr_ready;
    logic [31:0]       instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              illegal_seen;

    itype_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .flush(flush), .flush_pc(flush_pc), .illegal_seen(illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { int due; logic [31:0] word; } mem_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;

    mem_t inflight [$];
    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1, rdy_pct = 100, irdy_pct = 100, flush_pct = 0, rst_pm = 0;
    bit force_rst = 0;

    logic [31:0] m_pc;
    int          m_out = 0, m_cnt = 0, m_drop = 0, last_due = 0;
    bit          m_drain = 0, m_ill = 0, post_rst = 0;
    logic [31:0] last_pc = '0, last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_illegal(input logic [31:0] w);
        return w[6:0] != 7'b0010011;
    endfunction

    function automatic logic [31:0] filt(input logic [31:0] w);
`ifdef ITYPE_ILLEGAL_FILTER_EN
        return is_illegal(w) ? 32'h0000_0013 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w[6:0] = 7'b0010011;
        if ($urandom_range(0, 15) == 0) w = 32'h1234_5678;
        return w;
    endfunction

    // Reference model: credit/drain bookkeeping from the protocol rules, plus memory request capture.
    always @(negedge clk) begin
        bit accept, rsp, pop, push, exp_rv;
        mem_t m;
        exp_t e;
        if (rst) begin
            m_pc = RESET_PC; m_out = 0; m_cnt = 0; m_drop = 0;
            m_drain = 0; m_ill = 0; last_due = cyc; post_rst = 1;
        end else begin
            if (post_rst) begin
                chk("reset_instr_valid", 32'(instr_valid), 32'h0);
                chk("reset_instr_data", instr_data, 32'h0);
                chk("reset_instr_pc", instr_pc, 32'h0);
                chk("reset_illegal_seen", 32'(illegal_seen), 32'h0);
                chk("reset_req_addr", imem_req_addr, RESET_PC);
                post_rst = 0;
            end
            exp_rv = !m_drain && !flush && (m_cnt + m_out < DEPTH);
            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            chk("req_addr", imem_req_addr, m_pc);
            chk("instr_valid", 32'(instr_valid), 32'(m_cnt > 0));
            chk("illegal_seen", 32'(illegal_seen), 32'(m_ill));

            accept = imem_req_valid && imem_req_ready;
            rsp    = imem_rsp_valid;
            pop    = (m_cnt > 0) && instr_ready && !flush;
            push   = rsp && !flush && !m_drain;

            if (accept) begin
                m.word = gen_word();
                m.due  = cyc + $urandom_range(lat_min, lat_max);
                if (m.due <= last_due) m.due = last_due + 1;
                last_due = m.due;
                inflight.push_back(m);
                e.pc = m_pc;
                e.data = filt(m.word);
                exp_q.push_back(e);
            end
`ifdef ITYPE_ILLEGAL_FILTER_EN
            if (push && is_illegal(imem_rsp_data)) m_ill = 1;
`endif
            if (flush) begin
                if (!m_drain) m_drop = m_out - int'(rsp);
                else if (rsp) m_drop--;
                m_drain = (m_drop != 0);
                m_out = 0; m_cnt = 0;
                m_pc = flush_pc;
            end else if (m_drain) begin
                if (rsp) m_drop--;
                m_drain = (m_drop != 0);
            end else begin
                m_out = m_out + int'(accept) - int'(rsp);
                m_cnt = m_cnt + int'(rsp) - int'(pop);
                if (accept) m_pc = m_pc + 32'd4;
            end
        end
    end

    // Scoreboard monitor: compares the presented head and retires it on a handshake.
    always @(negedge clk) begin
        if (rst) begin
            last_pc = '0;
            last_data = '0;
        end else if (instr_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_instr: got pc %h, expected no instruction (cycle %0d)", instr_pc, cyc);
            end else begin
                chk("instr_pc", instr_pc, exp_q[0].pc);
                chk("instr_data", instr_data, exp_q[0].data);
                last_pc = exp_q[0].pc;
                last_data = exp_q[0].data;
                if (instr_ready && !flush) void'(exp_q.pop_front());
            end
        end else begin
            chk("hold_pc", instr_pc, last_pc);
            chk("hold_data", instr_data, last_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst || flush) exp_q.delete();
        if (rst) inflight.delete();
        rst = force_rst || ($urandom_range(0, 999) < rst_pm);
        force_rst = 0;
        if (!rst && inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inflight[0].word;
            void'(inflight.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
        instr_ready    = ($urandom_range(0, 99) < irdy_pct);
        flush          = ($urandom_range(0, 99) < flush_pct) && !(m_drain && imem_rsp_valid);
        flush_pc       = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic phase(input int n, input int lmin, input int lmax, input int rdy,
                         input int irdy, input int fl, input int rs);
        lat_min = lmin; lat_max = lmax; rdy_pct = rdy;
        irdy_pct = irdy; flush_pct = fl; rst_pm = rs;
        repeat (n) step();
    endtask

    initial begin
        bit done;
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; flush = 1'b0; flush_pc = '0;
        repeat (3) @(posedge clk);
        phase(40, 1, 1, 100, 100, 0, 0);     // streaming at one-cycle latency
        phase(30, 1, 1, 100, 0, 0, 0);       // consumer stalled: credits run out
        phase(30, 1, 2, 100, 30, 0, 0);      // slow consumer releases credits one at a time
        force_rst = 1;
        phase(1, 1, 2, 100, 30, 0, 0);       // reset with a full pipeline
        phase(300, 3, 3, 100, 50, 5, 0);     // fixed latency 3 with flushes
        phase(2000, 1, 4, 70, 60, 3, 2);     // mixed traffic, flushes and occasional resets
        lat_min = 1; lat_max = 2; rdy_pct = 0; irdy_pct = 100; flush_pct = 0; rst_pm = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            done = (exp_q.size() == 0) && (inflight.size() == 0) && (m_cnt == 0) && !m_drain;
        end
        @(negedge clk);
        chk("drain_complete", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
